// File: rtl/latch_readback_ctl_if.sv
// Handshake and data bundle between a latch bank and its readback controller.
// The master side raises requests and accepts serial bits; the slave is the controller.
interface latch_readback_ctl_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             RB_REQ;
    logic             RB_ABORT;
    logic [WIDTH-1:0] LQ;
    logic             SDO_RDY;
    logic             SDO;
    logic             SDO_VLD;
    logic             RB_BUSY;
    logic             RB_DONE;
    logic [WIDTH-1:0] SNAP;

    modport master (
        output RB_REQ, RB_ABORT, LQ, SDO_RDY,
        input  SDO, SDO_VLD, RB_BUSY, RB_DONE, SNAP
    );

    modport slave (
        input  RB_REQ, RB_ABORT, LQ, SDO_RDY,
        output SDO, SDO_VLD, RB_BUSY, RB_DONE, SNAP
    );
endinterface

// File: rtl/latch_readback_ctl.sv
// Latch-bank readback: settle, snapshot LQ into flops, then stream the snapshot
// LSB-first on a valid/ready serial port followed by an even-parity bit.
module latch_readback_ctl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                 C,
    input  logic                 CLRN,
    latch_readback_ctl_if.slave  bus
);
    localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SCW = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_PAR    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [SCW-1:0]   settle_q, settle_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [WIDTH-1:0] snap_q,   snap_d;
    logic             par_q,    par_d;
    logic             vld_q,    vld_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // shreg_q[0] is the bit currently presented on SDO; cleared whenever not valid
    always_ff @(posedge C or negedge CLRN) begin
        if (!CLRN) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            snap_q   <= '0;
            par_q    <= 1'b0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            snap_q   <= snap_d;
            par_q    <= par_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and registered-output values; holding is the default (stall)
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        snap_d   = snap_q;
        par_d    = par_q;
        vld_d    = vld_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.RB_REQ) begin
                    state_d  = ST_SETTLE;
                    settle_d = SCW'(SETTLE_CYC - 1);
                    busy_d   = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (bus.RB_ABORT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (settle_q == '0) begin
                    state_d  = ST_SHIFT;
                    snap_d   = bus.LQ;
                    shreg_d  = bus.LQ;
                    bitcnt_d = '0;
                    par_d    = 1'b0;
                    vld_d    = 1'b1;
                end else begin
                    settle_d = settle_q - SCW'(1);
                end
            end

            ST_SHIFT: begin
                if (bus.RB_ABORT) begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (bus.SDO_RDY) begin
                    par_d = par_q ^ shreg_q[0];
                    if (bitcnt_q == BCW'(WIDTH - 1)) begin
                        state_d = ST_PAR;
                        shreg_d = WIDTH'(par_q ^ shreg_q[0]);
                    end else begin
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + BCW'(1);
                    end
                end
            end

            ST_PAR: begin
                if (bus.RB_ABORT) begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (bus.SDO_RDY) begin
                    state_d = ST_DONE;
                    shreg_d = '0;
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.SDO     = shreg_q[0];
    assign bus.SDO_VLD = vld_q;
    assign bus.RB_BUSY = busy_q;
    assign bus.RB_DONE = done_q;
    assign bus.SNAP    = snap_q;
endmodule

// File: tb/tb_latch_readback_ctl.sv
// Randomised and directed bench for latch_readback_ctl against a frame-level
// reference model (settle countdown, bit position, parity by reduction).
module tb_latch_readback_ctl;
    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic C;
    logic CLRN;
    int   n_checks = 0;
    int   n_errors = 0;

    latch_readback_ctl_if #(.WIDTH(W)) bus ();

    latch_readback_ctl #(.WIDTH(W), .SETTLE_CYC(S)) dut (
        .C    (C),
        .CLRN (CLRN),
        .bus  (bus)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    // reference model: frame in progress, settle cycles left, bit position (-1 = none, W = parity)
    bit           m_busy;
    bit           m_done;
    int           m_wait;
    int           m_pos;
    logic [W-1:0] m_frame;
    logic [W-1:0] m_snap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_done  = 0;
        m_wait  = 0;
        m_pos   = -1;
        m_frame = '0;
        m_snap  = '0;
    endtask

    task automatic model_step();
        if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (bus.RB_REQ) begin
                m_busy = 1;
                m_wait = S - 1;
                m_pos  = -1;
            end
        end else if (bus.RB_ABORT) begin
            m_busy = 0;
            m_pos  = -1;
        end else if (m_pos < 0) begin
            if (m_wait == 0) begin
                m_snap  = bus.LQ;
                m_frame = bus.LQ;
                m_pos   = 0;
            end else begin
                m_wait--;
            end
        end else if (bus.SDO_RDY) begin
            m_pos++;
            if (m_pos > W) begin
                m_pos  = -1;
                m_done = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic e_vld;
        logic e_sdo;
        e_vld = m_busy && !m_done && (m_pos >= 0);
        e_sdo = !e_vld ? 1'b0 : (m_pos < W) ? m_frame[m_pos] : ^m_frame;
        check("sdo_vld", bus.SDO_VLD, e_vld);
        check("sdo",     bus.SDO,     e_sdo);
        check("rb_busy", bus.RB_BUSY, m_busy);
        check("rb_done", bus.RB_DONE, m_done);
        check("snap",    bus.SNAP,    m_snap);
    endtask

    task automatic tick();
        @(posedge C);
        model_step();
        #1;
        compare_all();
    endtask

    // One request from IDLE; optional stall of stall_len cycles while bit stall_at is offered
    task automatic run_frame(input string tag, input logic [W-1:0] lq_v, input logic [W-1:0] lq_after,
                             input int stall_at, input int stall_len);
        int         nbit;
        int         stalled;
        int         done_edge;
        logic [W:0] bits;
        nbit = 0; stalled = 0; done_edge = -1; bits = '0;
        bus.LQ = lq_v; bus.RB_REQ = 1'b1; bus.RB_ABORT = 1'b0; bus.SDO_RDY = 1'b1;
        for (int e = 0; e < 60 && done_edge < 0; e++) begin
            if (bus.SDO_VLD && nbit == stall_at && stalled < stall_len) begin
                bus.SDO_RDY = 1'b0;
                stalled++;
            end else begin
                bus.SDO_RDY = 1'b1;
            end
            if (bus.SDO_VLD && bus.SDO_RDY && nbit <= W) begin
                bits[nbit] = bus.SDO;
                nbit++;
            end
            tick();
            if (e == 0) bus.RB_REQ = 1'b0;
            if (bus.SDO_VLD) bus.LQ = lq_after;
            if (bus.RB_DONE) done_edge = e;
        end
        check({tag, "_done_edge"}, done_edge, S + W + 1 + stall_len);
        check({tag, "_bits"}, bits, {^lq_v, lq_v});
        check({tag, "_snap"}, bus.SNAP, lq_v);
    endtask

    initial begin
        logic [W-1:0] x;
        CLRN = 1'b0;
        bus.RB_REQ = 1'b0; bus.RB_ABORT = 1'b0; bus.SDO_RDY = 1'b0; bus.LQ = '0;
        model_reset();
        #1;
        compare_all();
        @(negedge C);
        CLRN = 1'b1;

        run_frame("a5", 8'hA5, 8'h5A, -1, 0);
        tick();
        run_frame("h07", 8'h07, 8'hFF, -1, 0);
        tick();
        x = W'($urandom);
        run_frame("stall", x, ~x, 3, 3);
        tick();

        // abort while bit 4 is offered, then an immediate new request
        bus.RB_REQ = 1'b1; bus.SDO_RDY = 1'b1; bus.LQ = W'($urandom);
        tick();
        bus.RB_REQ = 1'b0;
        for (int i = 0; i < 10 && !bus.SDO_VLD; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        bus.RB_ABORT = 1'b1;
        tick();
        bus.RB_ABORT = 1'b0;
        check("abort_busy", bus.RB_BUSY, 1'b0);
        check("abort_vld",  bus.SDO_VLD, 1'b0);
        run_frame("post_abort", 8'h3C, 8'h00, -1, 0);
        tick();

        // asynchronous reset between edges in the middle of SHIFT
        bus.RB_REQ = 1'b1; bus.LQ = W'($urandom);
        tick();
        bus.RB_REQ = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        CLRN = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_snap", bus.SNAP, '0);
        @(negedge C);
        CLRN = 1'b1;
        run_frame("post_rst", 8'hC3, 8'h11, -1, 0);
        tick();

        // request held high with a ready sink: back-to-back frames
        bus.RB_REQ = 1'b1; bus.SDO_RDY = 1'b1; bus.RB_ABORT = 1'b0;
        for (int i = 0; i < 120; i++) begin
            bus.LQ = W'($urandom);
            tick();
        end

        // fully random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.RB_REQ   = ($urandom_range(0, 3) == 0);
            bus.RB_ABORT = ($urandom_range(0, 24) == 0);
            bus.SDO_RDY  = ($urandom_range(0, 3) != 0);
            bus.LQ       = W'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
